// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared CPU definitions used by the divider: datapath width,
//               divider FSM state encoding and the DIV/DIVU funct codes that
//               execute decodes into start / is_signed.
// Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    // Default operand/result width of the integer datapath
    localparam int WIDTH = 32;

    // Divider FSM state encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    // R-type funct codes decoded by execute into start / is_signed
    localparam logic [5:0] C_FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] C_FUNCT_DIVU = 6'h1B;

endpackage : div_unit_pkg
`default_nettype wire

// File: rtl/div_unit_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring division iteration.
//               {rem, quo} is shifted left by one; the divisor is subtracted
//               from the widened partial remainder and the result is kept
//               only when it is non-negative.
// Ports       : i_rem      - current partial remainder
//               i_quo      - current quotient / remaining dividend bits
//               i_divisor  - divisor magnitude
//               o_rem      - next partial remainder
//               o_quo      - next quotient / remaining dividend bits
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;
    logic           w_neg;

    // The shifted remainder can need WIDTH+1 bits when the divisor is above
    // 2^(WIDTH-1), so the trial subtraction is done one bit wider. Because a
    // kept trial is always below the divisor and a rejected one is never
    // below -2^WIDTH, the top bit of the WIDTH+1 bit result is its sign.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, i_divisor};
    assign w_neg   = w_trial[WIDTH];

    always_comb begin
        o_quo = {i_quo[WIDTH-2:0], ~w_neg};
        o_rem = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle restoring divider for DIV/DIVU. Produces the LO
//               quotient and HI remainder plus a one-cycle HI/LO write strobe.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active low
//               start      - start request (IDLE only, ignored with cancel)
//               cancel     - pipeline flush, aborts the running operation
//               is_signed  - 1 = DIV, 0 = DIVU (sampled with start)
//               dividend   - numerator (sampled with start)
//               divisor    - denominator (sampled with start)
//               busy       - high in every state except IDLE
//               done       - one-cycle completion pulse
//               hilo_we    - done masked by cancel, enables HI and LO
//               quotient   - result for LO, held until next completion
//               remainder  - result for HI, held until next completion
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = div_unit_pkg::WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    import div_unit_pkg::*;

    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dsr;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dz;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_busy;
    logic             r_done;

    logic             w_dd_neg;
    logic             w_ds_neg;
    logic [WIDTH-1:0] w_dd_abs;
    logic [WIDTH-1:0] w_ds_abs;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Operand magnitudes; signs only matter for DIV
    assign w_dd_neg = is_signed & dividend[WIDTH-1];
    assign w_ds_neg = is_signed & divisor[WIDTH-1];
    assign w_dd_abs = w_dd_neg ? (~dividend + 1'b1) : dividend;
    assign w_ds_abs = w_ds_neg ? (~divisor  + 1'b1) : divisor;

    div_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_dsr),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    // With a zero divisor every step succeeds, so the quotient is all ones
    // and the remainder ends up as |dividend|; re-applying the dividend sign
    // therefore restores the original dividend for both DIV and DIVU.
    assign w_q_fix = r_dz     ? {WIDTH{1'b1}}
                   : r_sign_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix = r_sign_r ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dsr       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dz        <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !cancel) begin
                        r_quo    <= w_dd_abs;
                        r_dsr    <= w_ds_abs;
                        r_sign_q <= w_dd_neg ^ w_ds_neg;
                        r_sign_r <= w_dd_neg;
                        r_dz     <= (divisor == '0);
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST_STEP) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_quotient  <= w_q_fix;
                        r_remainder <= w_r_fix;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    // A flush in the completion cycle must keep HI/LO from being written
    assign hilo_we   = r_done & ~cancel;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit with an expected-result
//               queue filled at start and drained at each completion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cancel;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        hilo_we;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb[$];

    div_unit #(
        .WIDTH     (32),
        .CNT_W     (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cancel    (cancel),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .hilo_we   (hilo_we),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: C-style truncating division, DIV/0 and overflow rules
    function automatic exp_t model(input logic [31:0] dd, input logic [31:0] ds, input logic sg);
        exp_t e;
        int   a;
        int   b;
        if (ds == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = dd;
        end else if (!sg) begin
            e.q = dd / ds;
            e.r = dd % ds;
        end else if (dd == 32'h8000_0000 && ds == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else begin
            a   = $signed(dd);
            b   = $signed(ds);
            e.q = 32'(a / b);
            e.r = 32'(a % b);
        end
        return e;
    endfunction

    // Drive start during the next cycle (cycle 0 of an operation)
    task automatic kick(input logic [31:0] dd, input logic [31:0] ds, input logic sg);
        @(negedge clk);
        dividend  = dd;
        divisor   = ds;
        is_signed = sg;
        start     = 1'b1;
    endtask

    // Wait for hilo_we; cyc is the cycle index relative to the start cycle
    task automatic wait_done(output int cyc, output logic [31:0] q, output logic [31:0] r);
        cyc = -1;
        q   = 'x;
        r   = 'x;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (hilo_we === 1'b1) begin
                cyc = k;
                q   = quotient;
                r   = remainder;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, hilo_we} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: got busy/done/we=%b required 000", {busy, done, hilo_we});
        end
        checks++;
        if (quotient !== 32'd0 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: got q=%h r=%h required 0/0", quotient, remainder);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_divu_timing();
        int   done_cyc = -1;
        int   done_cnt = 0;
        bit   busy_bad = 0;
        exp_t e;
        logic [31:0] q;
        logic [31:0] r;
        kick(32'd100, 32'd7, 1'b0);
        sb.push_back(model(32'd100, 32'd7, 1'b0));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy !== (k <= 34)) busy_bad = 1;
            if (hilo_we === 1'b1 || done === 1'b1) begin
                done_cnt++;
                done_cyc = k;
                if (hilo_we !== done) busy_bad = 1;
                q = quotient;
                r = remainder;
            end
        end
        checks++;
        if (busy_bad) begin
            failures++;
            $display("FAIL divu_busy_trace: busy/we trace wrong, required busy high cycles 1..34");
        end
        checks++;
        if (done_cyc !== 34 || done_cnt !== 1) begin
            failures++;
            $display("FAIL divu_done_cycle: got cycle %0d count %0d required cycle 34 count 1", done_cyc, done_cnt);
        end
        e = sb.pop_front();
        checks++;
        if (q !== e.q || r !== e.r) begin
            failures++;
            $display("FAIL divu_100_7: got q=%h r=%h required q=%h r=%h", q, r, e.q, e.r);
        end
    endtask

    task automatic test_signed_and_special();
        logic [31:0] tdd [7] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB,
                                 32'hFFFF_FF9C, 32'hFFFF_FFFF};
        logic [31:0] tds [7] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0,
                                 32'hFFFF_FFF9, 32'h8000_0001};
        logic        tsg [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int   cyc;
        exp_t e;
        logic [31:0] q;
        logic [31:0] r;
        for (int i = 0; i < 7; i++) begin
            kick(tdd[i], tds[i], tsg[i]);
            sb.push_back(model(tdd[i], tds[i], tsg[i]));
            wait_done(cyc, q, r);
            e = sb.pop_front();
            checks++;
            if (cyc !== 34 || q !== e.q || r !== e.r) begin
                failures++;
                $display("FAIL div_case%0d: got cyc=%0d q=%h r=%h required cyc=34 q=%h r=%h",
                         i, cyc, q, r, e.q, e.r);
            end
        end
    endtask

    task automatic test_cancel();
        logic [31:0] q0;
        logic [31:0] r0;
        bit   we_seen = 0;
        int   cyc;
        exp_t e;
        logic [31:0] q;
        logic [31:0] r;
        q0 = quotient;
        r0 = remainder;
        kick(32'd100, 32'd7, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (hilo_we === 1'b1) we_seen = 1;
            if (k == 10) cancel = 1'b1;
            if (k == 11) begin
                cancel = 1'b0;
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL cancel_busy: got busy=%b at cycle 11 required 0", busy);
                end
            end
        end
        kick(32'd9, 32'd3, 1'b0);
        sb.push_back(model(32'd9, 32'd3, 1'b0));
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (hilo_we === 1'b1) we_seen = 1;
        end
        checks++;
        if (we_seen || quotient !== q0 || remainder !== r0) begin
            failures++;
            $display("FAIL cancel_hold: got we_seen=%0d q=%h r=%h required 0 q=%h r=%h",
                     we_seen, quotient, remainder, q0, r0);
        end
        cyc = -1;
        for (int k = 34; k <= 40; k++) begin
            @(negedge clk);
            if (hilo_we === 1'b1) begin
                cyc = k; q = quotient; r = remainder;
                break;
            end
        end
        e = sb.pop_front();
        checks++;
        if (cyc !== 34 || q !== e.q || r !== e.r) begin
            failures++;
            $display("FAIL after_cancel_9_3: got cyc=%0d q=%h r=%h required cyc=34 q=%h r=%h",
                     cyc, q, r, e.q, e.r);
        end
    endtask

    task automatic test_start_while_busy();
        int   cyc = -1;
        exp_t e;
        logic [31:0] q;
        logic [31:0] r;
        kick(32'd100, 32'd7, 1'b0);
        sb.push_back(model(32'd100, 32'd7, 1'b0));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 5) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b1;
            end
            if (k == 6) start = 1'b0;
            if (hilo_we === 1'b1) begin
                cyc = k; q = quotient; r = remainder;
                break;
            end
        end
        e = sb.pop_front();
        checks++;
        if (cyc !== 34 || q !== e.q || r !== e.r) begin
            failures++;
            $display("FAIL start_ignored: got cyc=%0d q=%h r=%h required cyc=34 q=%h r=%h",
                     cyc, q, r, e.q, e.r);
        end
    endtask

    task automatic test_cancel_in_done();
        logic seen_done = 1'b0;
        logic we_val    = 1'bx;
        kick(32'd20, 32'd4, 1'b0);
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 34) begin
                seen_done = done;
                cancel    = 1'b1;
                #1;
                we_val    = hilo_we;
            end
            if (k == 35) begin
                cancel = 1'b0;
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL cancel_done_idle: got busy=%b required 0", busy);
                end
            end
        end
        checks++;
        if (seen_done !== 1'b1 || we_val !== 1'b0) begin
            failures++;
            $display("FAIL cancel_in_done: got done=%b we=%b required done=1 we=0", seen_done, we_val);
        end
    endtask

    task automatic test_async_reset();
        int   cyc;
        exp_t e;
        logic [31:0] q;
        logic [31:0] r;
        kick(32'd100, 32'd7, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || quotient === 32'd0) begin
            failures++;
            $display("FAIL pre_reset: got busy=%b q=%h required busy=1 q nonzero", busy, quotient);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, hilo_we} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: got ctrl=%b q=%h r=%h required 000/0/0",
                     {busy, done, hilo_we}, quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b1;
        kick(32'd100, 32'd7, 1'b0);
        sb.push_back(model(32'd100, 32'd7, 1'b0));
        wait_done(cyc, q, r);
        e = sb.pop_front();
        checks++;
        if (cyc !== 34 || q !== e.q || r !== e.r) begin
            failures++;
            $display("FAIL post_reset_divu: got cyc=%0d q=%h r=%h required cyc=34 q=%h r=%h",
                     cyc, q, r, e.q, e.r);
        end
    endtask

    initial begin
        test_reset();
        test_divu_timing();
        test_signed_and_special();
        test_cancel();
        test_start_while_busy();
        test_cancel_in_done();
        test_async_reset();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %0d entries required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_div_unit
`default_nettype wire
